// File: rtl/serial_word_receiver_if.sv
// Bundles the serial bit stream, the parallel output handshake and the
// error-flag controls of serial_word_receiver.
interface serial_word_receiver_if #(
  parameter int WIDTH = 4
);
  logic             s_in;
  logic             s_valid;
  logic             s_start;
  logic             dir;
  logic             p_ready;
  logic             err_clr;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  modport master (
    output s_in, s_valid, s_start, dir, p_ready, err_clr,
    input  p_out, p_valid, busy, frame_err, overrun
  );

  modport slave (
    input  s_in, s_valid, s_start, dir, p_ready, err_clr,
    output p_out, p_valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver: assembles WIDTH framed bits (LSB- or MSB-first)
// into a word held on a valid/ready output buffer, with sticky error flags.
module serial_word_receiver #(
  parameter int WIDTH = 4
) (
  input logic                   clk,
  input logic                   clear,
  serial_word_receiver_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sh_r, sh_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             dir_r, dir_s;
  logic [WIDTH-1:0] p_out_r, p_out_s;
  logic             p_valid_r, p_valid_s;
  logic             frame_err_r, frame_err_s;
  logic             overrun_r, overrun_s;
  logic             word_done_s;
  logic             frame_hit_s;
  logic             overrun_hit_s;

  // Shift one bit into the word; msb_first selects which end it enters.
  function automatic logic [WIDTH-1:0] shift_in(
    input logic [WIDTH-1:0] sh,
    input logic             b,
    input logic             msb_first
  );
    logic [WIDTH-1:0] res;
    if (msb_first) begin
      res = {sh[WIDTH-2:0], b};
    end else begin
      res = {b, sh[WIDTH-1:1]};
    end
    return res;
  endfunction

  // Next-state, word assembly, output buffer and sticky-flag logic.
  always_comb begin
    state_s       = state_r;
    sh_s          = sh_r;
    cnt_s         = cnt_r;
    dir_s         = dir_r;
    p_out_s       = p_out_r;
    p_valid_s     = p_valid_r;
    frame_err_s   = frame_err_r;
    overrun_s     = overrun_r;
    word_done_s   = 1'b0;
    frame_hit_s   = 1'b0;
    overrun_hit_s = 1'b0;

    if (bus.s_valid) begin
      case (state_r)
        IDLE: begin
          if (bus.s_start) begin
            dir_s   = bus.dir;
            sh_s    = shift_in(sh_r, bus.s_in, bus.dir);
            cnt_s   = CW'(1);
            state_s = SHIFT;
          end else begin
            frame_hit_s = 1'b1;
          end
        end
        SHIFT: begin
          if (bus.s_start) begin
            // A start bit mid-word abandons the partial word and begins anew.
            frame_hit_s = 1'b1;
            dir_s       = bus.dir;
            sh_s        = shift_in(sh_r, bus.s_in, bus.dir);
            cnt_s       = CW'(1);
          end else begin
            sh_s = shift_in(sh_r, bus.s_in, dir_r);
            if (cnt_r == CW'(WIDTH - 1)) begin
              word_done_s = 1'b1;
              cnt_s       = {CW{1'b0}};
              state_s     = IDLE;
            end else begin
              cnt_s = cnt_r + CW'(1);
            end
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end

    if (p_valid_r && bus.p_ready) begin
      p_valid_s = 1'b0;
    end else begin
      p_valid_s = p_valid_r;
    end

    // A completed word loads only if the buffer is empty or draining this cycle.
    if (word_done_s) begin
      if (!p_valid_r || bus.p_ready) begin
        p_out_s   = sh_s;
        p_valid_s = 1'b1;
      end else begin
        overrun_hit_s = 1'b1;
      end
    end else begin
      p_out_s = p_out_r;
    end

    if (bus.err_clr) begin
      frame_err_s = 1'b0;
      overrun_s   = 1'b0;
    end else begin
      frame_err_s = frame_err_r;
      overrun_s   = overrun_r;
    end

    if (frame_hit_s) begin
      frame_err_s = 1'b1;
    end else begin
      frame_err_s = frame_err_s;
    end

    if (overrun_hit_s) begin
      overrun_s = 1'b1;
    end else begin
      overrun_s = overrun_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_r     <= IDLE;
      sh_r        <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      dir_r       <= 1'b0;
      p_out_r     <= {WIDTH{1'b0}};
      p_valid_r   <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      sh_r        <= sh_s;
      cnt_r       <= cnt_s;
      dir_r       <= dir_s;
      p_out_r     <= p_out_s;
      p_valid_r   <= p_valid_s;
      frame_err_r <= frame_err_s;
      overrun_r   <= overrun_s;
    end
  end

  assign bus.p_out     = p_out_r;
  assign bus.p_valid   = p_valid_r;
  assign bus.busy      = (state_r == SHIFT);
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WIDTH=4) with hand-computed expectations.
module tb_serial_word_receiver;

  logic clk;
  logic clear;
  int   total;
  int   passed;
  int   failed;

  serial_word_receiver_if #(.WIDTH(4)) bus ();

  serial_word_receiver #(.WIDTH(4)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with a valid bit presented; returns #1 after the sampling edge.
  task automatic bit_cycle(input logic b, input logic st, input logic d);
    bus.s_in    = b;
    bus.s_valid = 1'b1;
    bus.s_start = st;
    bus.dir     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    bus.s_valid = 1'b0;
    bus.s_start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    passed = 0;
    failed = 0;
    clear       = 1'b0;
    bus.s_in    = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_start = 1'b0;
    bus.dir     = 1'b0;
    bus.p_ready = 1'b1;
    bus.err_clr = 1'b0;
    #2;
    chk("rst_p_out", 32'(bus.p_out), 32'h0);
    chk("rst_p_valid", 32'(bus.p_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("rst_overrun", 32'(bus.overrun), 32'h0);
    #10;
    clear = 1'b1;
    @(posedge clk);
    #1;

    // 1: LSB-first 1,0,1,1 -> 4'b1101, one-cycle p_valid
    bit_cycle(1'b1, 1'b1, 1'b0);
    chk("t1_busy_after_start", 32'(bus.busy), 32'h1);
    bit_cycle(1'b0, 1'b0, 1'b0);
    bit_cycle(1'b1, 1'b0, 1'b0);
    chk("t1_p_valid_before_last", 32'(bus.p_valid), 32'h0);
    bit_cycle(1'b1, 1'b0, 1'b0);
    chk("t1_p_out", 32'(bus.p_out), 32'hD);
    chk("t1_p_valid", 32'(bus.p_valid), 32'h1);
    chk("t1_busy_done", 32'(bus.busy), 32'h0);
    idle_cycle();
    chk("t1_p_valid_drop", 32'(bus.p_valid), 32'h0);
    chk("t1_p_out_retained", 32'(bus.p_out), 32'hD);

    // 2: MSB-first 1,0,1,1 with dir toggling mid-word -> 4'b1011
    bit_cycle(1'b1, 1'b1, 1'b1);
    bit_cycle(1'b0, 1'b0, 1'b0);
    bit_cycle(1'b1, 1'b0, 1'b1);
    bit_cycle(1'b1, 1'b0, 1'b0);
    chk("t2_p_out", 32'(bus.p_out), 32'hB);
    chk("t2_p_valid", 32'(bus.p_valid), 32'h1);
    idle_cycle();
    chk("t2_p_valid_drop", 32'(bus.p_valid), 32'h0);

    // 3: same bits over 9 cycles with gaps
    bit_cycle(1'b1, 1'b1, 1'b0);
    idle_cycle();
    idle_cycle();
    chk("t3_busy_gap", 32'(bus.busy), 32'h1);
    bit_cycle(1'b0, 1'b0, 1'b0);
    idle_cycle();
    bit_cycle(1'b1, 1'b0, 1'b0);
    idle_cycle();
    chk("t3_busy_gap2", 32'(bus.busy), 32'h1);
    chk("t3_p_valid_gap", 32'(bus.p_valid), 32'h0);
    idle_cycle();
    bit_cycle(1'b1, 1'b0, 1'b0);
    chk("t3_p_out", 32'(bus.p_out), 32'hD);
    chk("t3_p_valid", 32'(bus.p_valid), 32'h1);
    chk("t3_busy_end", 32'(bus.busy), 32'h0);
    idle_cycle();

    // 4: overrun with p_ready=0: A=5 kept, B=A dropped
    bus.p_ready = 1'b0;
    bit_cycle(1'b1, 1'b1, 1'b0);
    bit_cycle(1'b0, 1'b0, 1'b0);
    bit_cycle(1'b1, 1'b0, 1'b0);
    bit_cycle(1'b0, 1'b0, 1'b0);
    chk("t4_a_p_out", 32'(bus.p_out), 32'h5);
    chk("t4_a_p_valid", 32'(bus.p_valid), 32'h1);
    chk("t4_no_overrun_yet", 32'(bus.overrun), 32'h0);
    bit_cycle(1'b0, 1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0, 1'b0);
    bit_cycle(1'b0, 1'b0, 1'b0);
    bit_cycle(1'b1, 1'b0, 1'b0);
    chk("t4_p_out_held", 32'(bus.p_out), 32'h5);
    chk("t4_overrun", 32'(bus.overrun), 32'h1);
    idle_cycle();
    chk("t4_overrun_sticky", 32'(bus.overrun), 32'h1);
    bus.err_clr = 1'b1;
    idle_cycle();
    bus.err_clr = 1'b0;
    chk("t4_overrun_cleared", 32'(bus.overrun), 32'h0);
    chk("t4_p_valid_still", 32'(bus.p_valid), 32'h1);
    bus.p_ready = 1'b1;
    idle_cycle();
    chk("t4_transfer_p_valid", 32'(bus.p_valid), 32'h0);
    chk("t4_transfer_p_out", 32'(bus.p_out), 32'h5);

    // 4b: completion while p_valid=1 and p_ready=1 loads the new word
    bus.p_ready = 1'b0;
    bit_cycle(1'b1, 1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0, 1'b0);
    bit_cycle(1'b0, 1'b0, 1'b0);
    bit_cycle(1'b0, 1'b0, 1'b0);
    chk("t4b_first_word", 32'(bus.p_out), 32'h3);
    bit_cycle(1'b1, 1'b1, 1'b0);
    bit_cycle(1'b0, 1'b0, 1'b0);
    bit_cycle(1'b0, 1'b0, 1'b0);
    bus.p_ready = 1'b1;
    bit_cycle(1'b1, 1'b0, 1'b0);
    chk("t4b_new_word", 32'(bus.p_out), 32'h9);
    chk("t4b_p_valid", 32'(bus.p_valid), 32'h1);
    chk("t4b_no_overrun", 32'(bus.overrun), 32'h0);
    idle_cycle();
    chk("t4b_p_valid_drop", 32'(bus.p_valid), 32'h0);

    // 5: restart mid-word -> frame_err, word 0,1,1,0 LSB-first = 4'b0110
    bit_cycle(1'b1, 1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0, 1'b0);
    chk("t5_no_frame_err_yet", 32'(bus.frame_err), 32'h0);
    bit_cycle(1'b0, 1'b1, 1'b0);
    chk("t5_frame_err", 32'(bus.frame_err), 32'h1);
    chk("t5_busy_restart", 32'(bus.busy), 32'h1);
    bit_cycle(1'b1, 1'b0, 1'b0);
    chk("t5_p_valid_mid", 32'(bus.p_valid), 32'h0);
    bit_cycle(1'b1, 1'b0, 1'b0);
    chk("t5_p_valid_mid2", 32'(bus.p_valid), 32'h0);
    bit_cycle(1'b0, 1'b0, 1'b0);
    chk("t5_p_out", 32'(bus.p_out), 32'h6);
    chk("t5_p_valid", 32'(bus.p_valid), 32'h1);
    idle_cycle();
    chk("t5_p_valid_drop", 32'(bus.p_valid), 32'h0);
    // err_clr colliding with a fresh stray bit: the error wins
    bus.err_clr = 1'b1;
    bit_cycle(1'b1, 1'b0, 1'b0);
    chk("t5_err_wins", 32'(bus.frame_err), 32'h1);
    chk("t5_stray_not_busy", 32'(bus.busy), 32'h0);
    idle_cycle();
    bus.err_clr = 1'b0;
    chk("t5_frame_err_cleared", 32'(bus.frame_err), 32'h0);

    // 6: asynchronous reset mid-word, then a clean MSB-first word 0,1,1,1 = 7
    bit_cycle(1'b1, 1'b1, 1'b0);
    bit_cycle(1'b0, 1'b0, 1'b0);
    bus.s_valid = 1'b0;
    #3;
    clear = 1'b0;
    #1;
    chk("t6_rst_p_out", 32'(bus.p_out), 32'h0);
    chk("t6_rst_p_valid", 32'(bus.p_valid), 32'h0);
    chk("t6_rst_busy", 32'(bus.busy), 32'h0);
    chk("t6_rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("t6_rst_overrun", 32'(bus.overrun), 32'h0);
    #2;
    clear = 1'b1;
    @(posedge clk);
    #1;
    bit_cycle(1'b0, 1'b1, 1'b1);
    bit_cycle(1'b1, 1'b0, 1'b1);
    bit_cycle(1'b1, 1'b0, 1'b1);
    bit_cycle(1'b1, 1'b0, 1'b1);
    chk("t6_p_out", 32'(bus.p_out), 32'h7);
    chk("t6_p_valid", 32'(bus.p_valid), 32'h1);
    chk("t6_frame_err", 32'(bus.frame_err), 32'h0);
    idle_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
